// File: rtl/matrix_pkg.sv
// Shared constants for the matrix stream memory: read-mode codes, FSM states
// and default geometry.
package matrix_pkg;

    localparam int unsigned DEF_ROWS = 10;
    localparam int unsigned DEF_COLS = 10;

    localparam logic [1:0] MODE_SNAP = 2'd0;
    localparam logic [1:0] MODE_ROW  = 2'd1;
    localparam logic [1:0] MODE_COL  = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/matrix_index_counter.sv
// Row/column position counter walking the matrix in row- or column-major order.
// Presents the linear index of the element that follows the current one.
module matrix_index_counter
    import matrix_pkg::*;
#(
    parameter int unsigned ROWS   = DEF_ROWS,
    parameter int unsigned COLS   = DEF_COLS,
    parameter int unsigned ADDR_W = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              col_major,
    input  logic              advance,
    output logic [ADDR_W-1:0] next_idx_c,
    output logic              last_c
);

    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW-1:0] R_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] C_MAX = CW'(COLS - 1);

    logic [RW-1:0] r_q, r_d;
    logic [CW-1:0] c_q, c_d;
    logic          col_major_q;

    // Inner counter wraps at its limit and carries into the outer counter.
    always_comb begin
        r_d = r_q;
        c_d = c_q;
        if (col_major_q) begin
            if (r_q == R_MAX) begin
                r_d = '0;
                c_d = (c_q == C_MAX) ? '0 : c_q + CW'(1);
            end else begin
                r_d = r_q + RW'(1);
            end
        end else begin
            if (c_q == C_MAX) begin
                c_d = '0;
                r_d = (r_q == R_MAX) ? '0 : r_q + RW'(1);
            end else begin
                c_d = c_q + CW'(1);
            end
        end
    end

    assign next_idx_c = ADDR_W'(r_d) * ADDR_W'(COLS) + ADDR_W'(c_d);
    assign last_c     = (r_q == R_MAX) && (c_q == C_MAX);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_q         <= '0;
            c_q         <= '0;
            col_major_q <= rst ? 1'b0 : col_major;
        end else if (advance) begin
            r_q <= r_d;
            c_q <= c_d;
        end
    end

endmodule

// File: rtl/matrix_stream_memory.sv
// ROWS x COLS element store with linear-address writes, full snapshot reads
// and row/column-major handshaked streaming.
module matrix_stream_memory
    import matrix_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ROWS   = DEF_ROWS,
    parameter int unsigned COLS   = DEF_COLS,
    parameter int unsigned ADDR_W = $clog2(ROWS * COLS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        wr_err,
    input  logic                        clr,
    input  logic                        rd_start,
    input  logic [1:0]                  rd_mode,
    output logic [DATA_W*ROWS*COLS-1:0] mat_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned       TOTAL    = ROWS * COLS;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TOTAL - 1);

    logic [DATA_W-1:0] mem [TOTAL];

    state_t            state_q, state_d;
    logic              do_write, do_clear, do_snap, do_start, do_adv, do_finish;
    logic              wr_drop;
    logic [ADDR_W-1:0] next_idx_c;
    logic              last_c;

    matrix_index_counter #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .ADDR_W (ADDR_W)
    ) u_index (
        .clk        (clk),
        .rst        (rst),
        .clear      (do_start),
        .col_major  (rd_mode == MODE_COL),
        .advance    (do_adv),
        .next_idx_c (next_idx_c),
        .last_c     (last_c)
    );

    // Next state and per-cycle actions; clr outranks rd_start, both block writes.
    always_comb begin
        state_d   = state_q;
        do_write  = 1'b0;
        do_clear  = 1'b0;
        do_snap   = 1'b0;
        do_start  = 1'b0;
        do_adv    = 1'b0;
        do_finish = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                do_clear = clr;
                do_write = wr_en && !clr && !rd_start && (32'(wr_addr) < TOTAL);
                if (rd_start && !clr) begin
                    if (rd_mode == MODE_SNAP) begin
                        do_snap = 1'b1;
                    end else if (rd_mode == MODE_ROW || rd_mode == MODE_COL) begin
                        do_start = 1'b1;
                        state_d  = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (out_valid && out_ready) begin
                    if (last_c) begin
                        do_finish = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        do_adv = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        wr_drop = wr_en && !do_write;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Storage is deliberately outside the reset domain; only clr zeroes it.
    always_ff @(posedge clk) begin
        if (do_clear) begin
            for (int k = 0; k < TOTAL; k++) begin
                mem[k] <= '0;
            end
        end else if (do_write) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err    <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            mat_data  <= '0;
        end else begin
            wr_err <= wr_drop;
            done   <= do_snap || do_finish;
            busy   <= (state_d == ST_STREAM);
            if (do_snap) begin
                for (int k = 0; k < TOTAL; k++) begin
                    mat_data[k*DATA_W +: DATA_W] <= mem[k];
                end
            end
            if (do_start) begin
                out_valid <= 1'b1;
                out_data  <= mem[0];
                out_last  <= (TOTAL == 1);
            end else if (do_adv) begin
                out_data <= mem[next_idx_c];
                out_last <= (next_idx_c == LAST_IDX);
            end else if (do_finish) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule
